// File: rtl/fetch_req_ctrl.sv
// In-order instruction-fetch request controller: issues memory requests, tracks
// outstanding/killed requests, and pairs responses with their PC from an external FIFO.
module fetch_req_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int MAX_OUT = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               pc_valid_i,
  output logic               pc_ready_o,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [ADDR_W-1:0]  mem_req_addr_o,
  input  logic               mem_rsp_valid_i,
  output logic               mem_rsp_ready_o,
  input  logic [INSTR_W-1:0] mem_rsp_data_i,
  input  logic               mem_rsp_err_i,
  output logic               fifo_push_o,
  output logic               fifo_pop_o,
  output logic               fifo_flush_o,
  output logic [ADDR_W-1:0]  fifo_pc_o,
  input  logic [ADDR_W-1:0]  fifo_pc_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_err_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      kill_cnt_q, kill_cnt_d;
  logic               instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_err_q, instr_err_d;

  logic can_issue, req_fire, rsp_acc, rsp_dec, live;

  always_comb begin
    can_issue       = (cnt_q < MAX_CNT) && !flush_i;
    mem_req_valid_o = pc_valid_i && can_issue;
    pc_ready_o      = mem_req_ready_i && can_issue;
    mem_req_addr_o  = pc_i;
    fifo_pc_o       = pc_i;
    req_fire        = mem_req_valid_o && mem_req_ready_i;
    fifo_push_o     = req_fire;
    fifo_flush_o    = flush_i;

    mem_rsp_ready_o = flush_i || (kill_cnt_q != '0) || !instr_valid_q || instr_ready_i;
    rsp_acc         = mem_rsp_valid_i && mem_rsp_ready_o;
    // A stray response with nothing outstanding must not wrap the counters.
    rsp_dec         = rsp_acc && (cnt_q != '0);
    live            = rsp_acc && (kill_cnt_q == '0) && !flush_i;
    fifo_pop_o      = live;

    cnt_d      = cnt_q + CW'(req_fire) - CW'(rsp_dec);
    kill_cnt_d = kill_cnt_q;
    if (flush_i) begin
      kill_cnt_d = cnt_q - CW'(rsp_dec);
    end else if (rsp_acc && (kill_cnt_q != '0)) begin
      kill_cnt_d = kill_cnt_q - 1'b1;
    end

    instr_valid_d = instr_valid_q;
    instr_pc_d    = instr_pc_q;
    instr_d       = instr_q;
    instr_err_d   = instr_err_q;
    if (flush_i) begin
      instr_valid_d = 1'b0;
    end else if (live) begin
      instr_valid_d = 1'b1;
      instr_pc_d    = fifo_pc_i;
      instr_d       = mem_rsp_data_i;
      instr_err_d   = mem_rsp_err_i;
    end else if (instr_ready_i) begin
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q         <= '0;
      kill_cnt_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      instr_q       <= '0;
      instr_err_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      kill_cnt_q    <= kill_cnt_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
      instr_q       <= instr_d;
      instr_err_q   <= instr_err_d;
    end
  end

  assign instr_valid_o = instr_valid_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_o       = instr_q;
  assign instr_err_o   = instr_err_q;

`ifndef SYNTHESIS
  a_rsp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    rsp_acc |-> (cnt_q != '0));
  a_kill_le_cnt: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    kill_cnt_q <= cnt_q);
  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (instr_valid_q && !instr_ready_i) |=> $stable({instr_pc_q, instr_q, instr_err_q}));
`endif

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Randomized bench for fetch_req_ctrl: memory, PC FIFO and a request-level
// reference model (list of outstanding requests with killed flags) live here.
module tb_fetch_req_ctrl;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int MAX_OUT = 4;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic               flush_i, pc_valid_i, pc_ready_o;
  logic [ADDR_W-1:0]  pc_i, mem_req_addr_o, fifo_pc_o, fifo_pc_i, instr_pc_o;
  logic               mem_req_valid_o, mem_req_ready_i;
  logic               mem_rsp_valid_i, mem_rsp_ready_o, mem_rsp_err_i;
  logic [INSTR_W-1:0] mem_rsp_data_i, instr_o;
  logic               fifo_push_o, fifo_pop_o, fifo_flush_o;
  logic               instr_valid_o, instr_ready_i, instr_err_o;

  fetch_req_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o), .pc_i(pc_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
    .fifo_push_o(fifo_push_o), .fifo_pop_o(fifo_pop_o), .fifo_flush_o(fifo_flush_o),
    .fifo_pc_o(fifo_pc_o), .fifo_pc_i(fifo_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_pc_o(instr_pc_o), .instr_o(instr_o), .instr_err_o(instr_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: outstanding requests in issue order; killed ones form a prefix.
  typedef struct {
    logic [ADDR_W-1:0] pc;
    bit                killed;
  } req_t;
  req_t              outq[$];
  logic [ADDR_W-1:0] fifoq[$];

  bit                 m_vld;
  logic [ADDR_W-1:0]  m_pc;
  logic [INSTR_W-1:0] m_data;
  bit                 m_err;

  always_comb fifo_pc_i = (fifoq.size() != 0) ? fifoq[0] : '0;

  task automatic model_clear();
    outq.delete();
    fifoq.delete();
    m_vld = 0; m_pc = '0; m_data = '0; m_err = 0;
  endtask

  task automatic drive_idle();
    flush_i = 0; pc_valid_i = 0; pc_i = '0; mem_req_ready_i = 0;
    mem_rsp_valid_i = 0; mem_rsp_data_i = '0; mem_rsp_err_i = 0; instr_ready_i = 0;
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_vld"},  instr_valid_o, 1'b0);
    chk({tag, "_pc"},   instr_pc_o, '0);
    chk({tag, "_data"}, instr_o, '0);
    chk({tag, "_err"},  instr_err_o, 1'b0);
  endtask

  int unsigned rsp_pct, flush_pct, rdy_pct;

  initial begin
    bit                 e_can, e_rspr, rsp_acc, live, fire;
    logic [INSTR_W-1:0] s_data;
    logic [ADDR_W-1:0]  s_pc;
    bit                 s_err, s_flush, s_rdy;

    rst_n_i = 0;
    drive_idle();
    model_clear();
    #12;
    chk_regs_zero("reset");
    @(negedge clk_i);
    rst_n_i = 1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) begin
        rsp_pct   = $urandom_range(10, 90);
        flush_pct = $urandom_range(0, 8);
        rdy_pct   = $urandom_range(20, 100);
      end
      @(negedge clk_i);
      if (cyc == 2000) begin
        // Asynchronous reset in the middle of traffic: outputs clear before any edge.
        rst_n_i = 0;
        #1;
        chk_regs_zero("async_rst");
        model_clear();
        drive_idle();
        @(negedge clk_i);
        chk_regs_zero("in_rst");
        rst_n_i = 1;
        continue;
      end

      flush_i         = ($urandom_range(0, 99) < flush_pct);
      pc_valid_i      = ($urandom_range(0, 99) < 75);
      pc_i            = {$urandom, $urandom} & ~64'h3;
      mem_req_ready_i = ($urandom_range(0, 99) < 75);
      mem_rsp_valid_i = (outq.size() != 0) && ($urandom_range(0, 99) < rsp_pct);
      mem_rsp_data_i  = $urandom;
      mem_rsp_err_i   = ($urandom_range(0, 9) == 0);
      instr_ready_i   = ($urandom_range(0, 99) < rdy_pct);
      #1;

      e_can   = (outq.size() < MAX_OUT) && !flush_i;
      e_rspr  = flush_i || (outq.size() != 0 && outq[0].killed) || !m_vld || instr_ready_i;
      rsp_acc = mem_rsp_valid_i && e_rspr;
      live    = rsp_acc && !flush_i && !outq[0].killed;
      fire    = pc_valid_i && mem_req_ready_i && e_can;

      chk("req_valid", mem_req_valid_o, pc_valid_i && e_can);
      chk("pc_ready",  pc_ready_o, mem_req_ready_i && e_can);
      chk("req_addr",  mem_req_addr_o, pc_i);
      chk("fifo_pc_o", fifo_pc_o, pc_i);
      chk("push",      fifo_push_o, fire);
      chk("flush",     fifo_flush_o, flush_i);
      chk("rsp_ready", mem_rsp_ready_o, e_rspr);
      chk("pop",       fifo_pop_o, live);
      chk("instr_vld", instr_valid_o, m_vld);
      if (m_vld) begin
        chk("instr_pc",   instr_pc_o, m_pc);
        chk("instr_data", instr_o, m_data);
        chk("instr_err",  instr_err_o, m_err);
      end

      s_data  = mem_rsp_data_i;
      s_err   = mem_rsp_err_i;
      s_pc    = pc_i;
      s_flush = flush_i;
      s_rdy   = instr_ready_i;

      @(posedge clk_i);
      #1;
      // Environment FIFO follows the DUT's controls.
      if (fifo_flush_o_s(s_flush)) fifoq.delete();
      else if (live && fifoq.size() != 0) void'(fifoq.pop_front());
      if (fire) fifoq.push_back(s_pc);

      if (s_flush) begin
        m_vld = 0;
      end else if (live) begin
        m_vld = 1; m_pc = outq[0].pc; m_data = s_data; m_err = s_err;
      end else if (s_rdy) begin
        m_vld = 0;
      end
      if (rsp_acc) void'(outq.pop_front());
      if (s_flush) foreach (outq[i]) outq[i].killed = 1;
      if (fire) outq.push_back('{pc: s_pc, killed: 0});
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  function automatic bit fifo_flush_o_s(input bit f);
    return f;
  endfunction

endmodule

// File: doc/fetch_req_ctrl.md
Name: fetch_req_ctrl

Overview:
Instruction-fetch request controller. It issues in-order instruction memory requests from the PC generator and tracks outstanding requests. It drives push/pop/flush of an external fifo_nohs (DEPTH = MAX_OUT) that holds the PC of each live request. It pairs each memory response with the PC at the FIFO head and forwards the pair downstream through a one-entry valid/ready output register. Responses belonging to requests issued before a flush are silently dropped.

Parameters:
ADDR_W, 64, PC / request address width
INSTR_W, 32, instruction (response data) width
MAX_OUT, 4, maximum outstanding memory requests; equals the DEPTH of the attached fifo_nohs

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
flush_i  in  1  pipeline flush (branch mispredict / exception)
pc_valid_i  in  1  PC generator has a fetch address
pc_ready_o  out  1  fetch address accepted this cycle
pc_i  in  ADDR_W  fetch address
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  ADDR_W  request address
mem_rsp_valid_i  in  1  memory response valid (responses in request order)
mem_rsp_ready_o  out  1  response accepted
mem_rsp_data_i  in  INSTR_W  fetched instruction
mem_rsp_err_i  in  1  access fault
fifo_push_o  out  1  FIFO push
fifo_pop_o  out  1  FIFO pop
fifo_flush_o  out  1  FIFO flush
fifo_pc_o  out  ADDR_W  FIFO write data
fifo_pc_i  in  ADDR_W  FIFO head data
instr_valid_o  out  1  fetched instruction valid
instr_ready_i  in  1  downstream accepts
instr_pc_o  out  ADDR_W  PC of instruction
instr_o  out  INSTR_W  instruction
instr_err_o  out  1  access fault flag

Behaviour:
- State registers:
  - cnt: total outstanding requests, including killed ones. Width $clog2(MAX_OUT+1).
  - kill_cnt: outstanding requests to discard. Same width.
  - Output register: instr_valid_o, instr_pc_o, instr_o, instr_err_o.
- Reset: all registers are 0, so every registered output is 0 after reset.
- Request path (combinational pass-through):
  - can_issue = (cnt < MAX_OUT) && !flush_i. Uses registered cnt; a same-cycle response does not free a slot.
  - mem_req_valid_o = pc_valid_i && can_issue.
  - pc_ready_o = mem_req_ready_i && can_issue.
  - mem_req_addr_o = fifo_pc_o = pc_i.
  - req_fire = mem_req_valid_o && mem_req_ready_i.
  - fifo_push_o = req_fire.
- Response path:
  - mem_rsp_ready_o = flush_i || (kill_cnt != 0) || !instr_valid_o || instr_ready_i.
  - rsp_acc = mem_rsp_valid_i && mem_rsp_ready_o.
  - live = rsp_acc && kill_cnt == 0 && !flush_i.
  - fifo_pop_o = live. Killed responses never pop, because their FIFO entries were flushed.
- Output register:
  - On live: load {fifo_pc_i, mem_rsp_data_i, mem_rsp_err_i} and set instr_valid_o = 1.
  - Else if instr_ready_i: instr_valid_o = 0.
  - Latency from response accept to instr_valid_o: 1 cycle.
  - Payload holds stable while instr_valid_o && !instr_ready_i.
  - Back-to-back throughput: 1 instruction per cycle when instr_ready_i = 1.
- Counters (no flush):
  - cnt <= cnt + req_fire - rsp_acc.
  - kill_cnt decrements on rsp_acc when kill_cnt != 0.
- Flush cycle:
  - No request fires.
  - Any response accepted in the flush cycle is dropped.
  - cnt <= cnt - rsp_acc.
  - kill_cnt <= cnt - rsp_acc, so every still-outstanding request becomes killed.
  - instr_valid_o <= 0.
  - fifo_flush_o = flush_i.
- After flush:
  - New requests may issue immediately in the next cycle, bounded by cnt < MAX_OUT.
  - Responses are in order, so the first kill_cnt responses are dropped and later ones are live.
- Invariant: FIFO occupancy = cnt - kill_cnt <= MAX_OUT.
- Boundaries:
  - cnt == MAX_OUT: pc_ready_o = 0 and mem_req_valid_o = 0.
  - A response with cnt == 0 is a protocol error. Flag it with an assertion; counters must not underflow (saturate at 0).
  - Reset mid-operation: all state clears asynchronously. Responses to pre-reset requests are the memory's responsibility (memory is reset too).
- Assertions (non-synthesis):
  - No rsp_acc when cnt == 0.
  - kill_cnt <= cnt.
  - Output payload is stable under backpressure.

Test Plan:
- Reset, then pc_valid_i = 1 with pc_i = 0x1000, 0x1004 and mem_req_ready_i = 1; memory responds 0x00000013 and 0x00100093 one cycle later each -> instr_valid_o on consecutive cycles with instr_pc_o = 0x1000 then 0x1004, correct data, err = 0.
- 4 requests issued, no responses -> cnt = 4; with pc_valid_i still high, pc_ready_o = 0 and mem_req_valid_o = 0. First response -> issue resumes the cycle after.
- 3 requests outstanding, flush_i pulsed, then new PC 0x2000 issued -> first 3 responses are accepted and dropped (instr_valid_o stays 0, fifo_pop_o = 0). 4th response emits instr_pc_o = 0x2000.
- Flush in the same cycle as a response accept with 2 outstanding -> that response is dropped, kill_cnt = 1, and the next response is also dropped.
- instr_ready_i = 0 with instr_valid_o = 1 and another response pending -> mem_rsp_ready_o = 0 and outputs hold. instr_ready_i = 1 -> pending response is accepted and output the next cycle.
- Response with mem_rsp_err_i = 1 at PC 0x3000 -> instr_err_o = 1, instr_pc_o = 0x3000. Async reset asserted mid-stream -> all outputs 0 immediately.
